// File: rtl/matrix_3x3_gen.sv
// 3x3 neighbourhood builder: shifts in the line-buffer taps per accepted beat and flags geometrically valid windows.
// Optional MATRIX_BORDER_REPLICATE_EN: also emit row-0/col-0 centres with edge replication on the output muxes.
module matrix_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  in_vsync,
  input  logic                  in_href,
  input  logic                  in_clken,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] tap0,
  input  logic [DATA_WIDTH-1:0] tap1,
  output logic [DATA_WIDTH-1:0] m11,
  output logic [DATA_WIDTH-1:0] m12,
  output logic [DATA_WIDTH-1:0] m13,
  output logic [DATA_WIDTH-1:0] m21,
  output logic [DATA_WIDTH-1:0] m22,
  output logic [DATA_WIDTH-1:0] m23,
  output logic [DATA_WIDTH-1:0] m31,
  output logic [DATA_WIDTH-1:0] m32,
  output logic [DATA_WIDTH-1:0] m33,
  output logic                  out_valid,
  output logic                  out_href,
  output logic                  out_vsync,
  output logic                  err_overrun
);

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT);
`ifdef MATRIX_BORDER_REPLICATE_EN
  localparam int MIN_POS = 1;
`else
  localparam int MIN_POS = 2;
`endif
  localparam logic [CW-1:0] COL_MIN = CW'(MIN_POS);
  localparam logic [RW-1:0] ROW_MIN = RW'(MIN_POS);

  logic                  vsync_prev_q, href_prev_q, frame_active_q;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic                  href_q, vsync_q;
  logic [DATA_WIDTH-1:0] win_q   [3][3];
  logic [DATA_WIDTH-1:0] win_out [3][3];

  logic vsync_rise, href_fall, beat, overrun, in_window;

  assign vsync_rise = in_vsync & ~vsync_prev_q;
  assign href_fall  = ~in_href & href_prev_q & frame_active_q;
  // A beat coinciding with a frame start is dropped so the new frame starts cleanly at (0,0).
  assign beat       = in_clken & in_href & frame_active_q & ~vsync_rise;
  assign overrun    = (col_q == COL_MAX) || (row_q == ROW_MAX);
  assign in_window  = (col_q >= COL_MIN) && (row_q >= ROW_MIN);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    valid_d = 1'b0;
    if (vsync_rise) begin
      col_d = '0;
      row_d = '0;
      err_d = 1'b0;
    end else if (href_fall) begin
      col_d = '0;
      if (row_q != ROW_MAX) row_d = row_q + RW'(1);
    end else if (beat) begin
      if (overrun) err_d = 1'b1;
      else         valid_d = in_window;
      if (col_q != COL_MAX) col_d = col_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_q   <= 1'b0;
      href_prev_q    <= 1'b0;
      frame_active_q <= 1'b0;
      col_q          <= '0;
      row_q          <= '0;
      err_q          <= 1'b0;
      valid_q        <= 1'b0;
      href_q         <= 1'b0;
      vsync_q        <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win_q[i][j] <= '0;
    end else begin
      vsync_prev_q <= in_vsync;
      href_prev_q  <= in_href;
      if (vsync_rise) frame_active_q <= 1'b1;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      href_q  <= in_href;
      vsync_q <= in_vsync;
      if (beat) begin
        for (int i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
        end
        win_q[0][2] <= tap1;
        win_q[1][2] <= tap0;
        win_q[2][2] <= in_data;
      end
    end
  end

`ifdef MATRIX_BORDER_REPLICATE_EN
  logic top_rep_q, left_rep_q;
  logic [DATA_WIDTH-1:0] top_sel [3][3];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      top_rep_q  <= 1'b0;
      left_rep_q <= 1'b0;
    end else if (beat) begin
      top_rep_q  <= (row_q == RW'(1));
      left_rep_q <= (col_q == CW'(1));
    end
  end

  // Top-row substitution first, so the corner at (1,1) collapses onto the centre.
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        top_sel[i][j] = win_q[i][j];
    if (top_rep_q)
      for (int j = 0; j < 3; j++) top_sel[0][j] = win_q[1][j];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win_out[i][j] = top_sel[i][j];
    if (left_rep_q)
      for (int i = 0; i < 3; i++) win_out[i][0] = top_sel[i][1];
  end
`else
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win_out[i][j] = win_q[i][j];
  end
`endif

  assign m11 = win_out[0][0];
  assign m12 = win_out[0][1];
  assign m13 = win_out[0][2];
  assign m21 = win_out[1][0];
  assign m22 = win_out[1][1];
  assign m23 = win_out[1][2];
  assign m31 = win_out[2][0];
  assign m32 = win_out[2][1];
  assign m33 = win_out[2][2];

  assign out_valid   = valid_q;
  assign out_href    = href_q;
  assign out_vsync   = vsync_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Bench for matrix_3x3_gen: image-array reference model with clamped indexing, random pixels and strobe gaps.
module tb_matrix_3x3_gen;
  localparam int W = 4;
  localparam int H = 4;
`ifdef MATRIX_BORDER_REPLICATE_EN
  localparam int MINV = 1;
`else
  localparam int MINV = 2;
`endif

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_vsync = 1'b0, in_href = 1'b0, in_clken = 1'b0;
  logic [7:0] in_data = '0, tap0 = '0, tap1 = '0;
  logic [7:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
  logic       out_valid, out_href, out_vsync, err_overrun;
  logic [7:0] act [9];
  logic [7:0] pix [H][W];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  matrix_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8)) dut (
    .clock(clock), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href), .in_clken(in_clken),
    .in_data(in_data), .tap0(tap0), .tap1(tap1),
    .m11(m11), .m12(m12), .m13(m13), .m21(m21), .m22(m22), .m23(m23),
    .m31(m31), .m32(m32), .m33(m33),
    .out_valid(out_valid), .out_href(out_href), .out_vsync(out_vsync), .err_overrun(err_overrun)
  );

  always_comb begin
    act[0] = m11; act[1] = m12; act[2] = m13;
    act[3] = m21; act[4] = m22; act[5] = m23;
    act[6] = m31; act[7] = m32; act[8] = m33;
  end

  // Image pixel with coordinates clamped to the frame; clamping is exactly edge replication.
  function automatic logic [7:0] px(input int r, input int c);
    if (r < 0) r = 0;
    if (c < 0) c = 0;
    return pix[r][c];
  endfunction

  function automatic logic [7:0] above(input int r, input int c);
    if (r < 0) return 8'h00;
    return pix[r][c];
  endfunction

  task automatic drive(input logic vs, input logic hr, input logic ck,
                       input logic [7:0] d, input logic [7:0] t0, input logic [7:0] t1);
    in_vsync = vs; in_href = hr; in_clken = ck;
    in_data = d; tap0 = t0; tap1 = t1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (act[i] !== 8'h00) begin
        n_bad++; $display("FAIL reset_win[%0d]: got %h want 00", i, act[i]);
      end
    end
    n_cmp++;
    if ({out_valid, out_href, out_vsync, err_overrun} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {out_valid, out_href, out_vsync, err_overrun});
    end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  // Beats before any vsync rise must be ignored; six beats would overrun a counting design.
  task automatic test_pre_vsync();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 6; c++) begin
        drive(0, 1, 1, 8'($urandom), 8'($urandom), 8'($urandom));
        n_cmp++;
        if (out_valid !== 1'b0 || err_overrun !== 1'b0) begin
          n_bad++; $display("FAIL pre_vsync: got valid=%b err=%b want 0/0", out_valid, err_overrun);
        end
      end
      drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    end
    n_cmp++;
    if (out_href !== 1'b0) begin
      n_bad++; $display("FAIL out_href_delay: got %b want 0", out_href);
    end
    $display("test_pre_vsync done");
  endtask

  task automatic run_frame(input bit patterned, input int ck_mode, input bit vsync_beat, input string tag);
    logic [7:0] exp_win [9];
    logic [7:0] first_exp [9];
    bit have_exp = 0;
    bit first = 1;
    int pulses = 0;
    int gaps;
    bit exp_v;
`ifdef MATRIX_BORDER_REPLICATE_EN
    first_exp = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h10, 8'h10, 8'h11};
`else
    first_exp = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
`endif
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pix[r][c] = patterned ? 8'(16 * r + c) : 8'($urandom);

    if (vsync_beat) begin
      drive(1, 1, 1, 8'($urandom), 8'($urandom), 8'($urandom));
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL %s vsync_beat_valid: got %b want 0", tag, out_valid);
      end
    end else begin
      drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
      n_cmp++;
      if (out_vsync !== 1'b1) begin
        n_bad++; $display("FAIL %s out_vsync_delay: got %b want 1", tag, out_vsync);
      end
      drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    end

    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        gaps = (ck_mode == 1) ? 1 : (ck_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int g = 0; g < gaps; g++) begin
          drive(0, 1, 0, 8'($urandom), 8'($urandom), 8'($urandom));
          n_cmp++;
          if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL %s gap_valid r%0d c%0d: got %b want 0", tag, r, c, out_valid);
          end
          if (have_exp) begin
            for (int i = 0; i < 9; i++) begin
              n_cmp++;
              if (act[i] !== exp_win[i]) begin
                n_bad++; $display("FAIL %s hold_win[%0d] r%0d c%0d: got %h want %h", tag, i, r, c, act[i], exp_win[i]);
              end
            end
          end
        end
        drive(0, 1, 1, pix[r][c], above(r - 1, c), above(r - 2, c));
        exp_v = (r >= MINV) && (c >= MINV);
        n_cmp++;
        if (out_valid !== exp_v) begin
          n_bad++; $display("FAIL %s valid r%0d c%0d: got %b want %b", tag, r, c, out_valid, exp_v);
        end
        have_exp = exp_v;
        if (exp_v) begin
          pulses++;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              exp_win[3 * i + j] = px(r - 2 + i, c - 2 + j);
          for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (act[i] !== exp_win[i]) begin
              n_bad++; $display("FAIL %s win[%0d] r%0d c%0d: got %h want %h", tag, i, r, c, act[i], exp_win[i]);
            end
          end
          if (patterned && first) begin
            for (int i = 0; i < 9; i++) begin
              n_cmp++;
              if (act[i] !== first_exp[i]) begin
                n_bad++; $display("FAIL %s first_win[%0d]: got %h want %h", tag, i, act[i], first_exp[i]);
              end
            end
          end
          first = 0;
        end
      end
      for (int k = 0; k < 2; k++) begin
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_bad++; $display("FAIL %s blank_valid r%0d: got %b want 0", tag, r, out_valid);
        end
      end
    end
    n_cmp++;
    if (pulses != (H - MINV) * (W - MINV) || err_overrun !== 1'b0) begin
      n_bad++; $display("FAIL %s pulses: got %0d err=%b want %0d err=0", tag, pulses, err_overrun, (H - MINV) * (W - MINV));
    end
    $display("frame %s done: %0d valid windows", tag, pulses);
  endtask

  task automatic test_frame_pattern();
    run_frame(1, 0, 0, "pattern");
  endtask

  task automatic test_clken_toggle();
    run_frame(1, 1, 0, "clken_toggle");
  endtask

  task automatic test_back_to_back();
    run_frame(0, 2, 0, "random0");
    run_frame(0, 2, 1, "random_vsync_beat");
    run_frame(0, 0, 0, "random1");
  endtask

  task automatic test_overrun();
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < W; c++) drive(0, 1, 1, 8'($urandom), 8'($urandom), 8'($urandom));
      drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    end
    for (int c = 0; c <= W; c++) begin
      drive(0, 1, 1, 8'($urandom), 8'($urandom), 8'($urandom));
      n_cmp++;
      if (out_valid !== (c >= MINV && c < W) || err_overrun !== (c == W)) begin
        n_bad++; $display("FAIL col_overrun c%0d: got valid=%b err=%b want %b/%b", c, out_valid, err_overrun, (c >= MINV && c < W), (c == W));
      end
    end
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (err_overrun !== 1'b1) begin
      n_bad++; $display("FAIL overrun_sticky: got %b want 1", err_overrun);
    end
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (err_overrun !== 1'b0) begin
      n_bad++; $display("FAIL overrun_clear: got %b want 0", err_overrun);
    end
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int r = 0; r <= H; r++) begin
      drive(0, 1, 1, 8'($urandom), 8'($urandom), 8'($urandom));
      n_cmp++;
      if (out_valid !== 1'b0 || err_overrun !== (r == H)) begin
        n_bad++; $display("FAIL row_overrun r%0d: got valid=%b err=%b want 0/%b", r, out_valid, err_overrun, (r == H));
      end
      drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    end
    $display("test_overrun done");
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < W; c++) drive(0, 1, 1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
      drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    end
    for (int c = 0; c < 3; c++) drive(0, 1, 1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_valid: got %b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (act[i] !== 8'h00) begin
        n_bad++; $display("FAIL async_reset_win[%0d]: got %h want 00", i, act[i]);
      end
    end
    n_cmp++;
    if ({out_valid, out_href, err_overrun} !== 3'b000) begin
      n_bad++; $display("FAIL async_reset_flags: got %b want 000", {out_valid, out_href, err_overrun});
    end
    @(posedge clock);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 1, 8'($urandom), 8'($urandom), 8'($urandom));
      n_cmp++;
      if (out_valid !== 1'b0 || err_overrun !== 1'b0) begin
        n_bad++; $display("FAIL post_reset_beat c%0d: got valid=%b err=%b want 0/0", c, out_valid, err_overrun);
      end
    end
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00);
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_pre_vsync();
    test_frame_pattern();
    test_clken_toggle();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    run_frame(0, 2, 0, "after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
